dir_request_arbiter: RTL and testbench

//   Request front end of the MSI directory. Buffers coherence requests from the two

---
 rtl/dir_request_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dir_request_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dir_request_arbiter.sv
// MSI directory request front end: per-processor FIFOs feeding a one-at-a-time issue FSM.
// Latency: 2 cycles push-to-offer; backpressure: PxReqReady = FIFO not full, offers held while DirReqReady low.
module dir_req_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dat   = r_mem[r_rptr];
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (i_push) r_mem[r_wptr] <= i_dat;
  end
endmodule

module dir_request_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              P0ReqValid,
  output logic              P0ReqReady,
  input  logic [1:0]        P0ReqOp,
  input  logic [ADDR_W-1:0] P0ReqAddr,
  input  logic [DATA_W-1:0] P0ReqData,
  input  logic              P1ReqValid,
  output logic              P1ReqReady,
  input  logic [1:0]        P1ReqOp,
  input  logic [ADDR_W-1:0] P1ReqAddr,
  input  logic [DATA_W-1:0] P1ReqData,
  output logic              DirReqValid,
  input  logic              DirReqReady,
  output logic [1:0]        DirReqOp,
  output logic [ADDR_W-1:0] DirReqAddr,
  output logic [DATA_W-1:0] DirReqData,
  output logic              DirReqProc,
  input  logic              DirDone
);
  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_WAIT} state_t;

  state_t r_state, w_state_nxt;
  req_t   r_req;
  logic   r_vld, r_proc, r_rr;
  req_t   w_p0_in, w_p1_in, w_p0_head, w_p1_head, w_win;
  logic   w_p0_push, w_p1_push, w_p0_full, w_p1_full, w_p0_empty, w_p1_empty;
  logic   w_wb0, w_wb1, w_sel, w_load, w_accept;

  assign P0ReqReady = ~w_p0_full;
  assign P1ReqReady = ~w_p1_full;
  assign w_p0_push  = P0ReqValid & P0ReqReady & (P0ReqOp != 2'b00);
  assign w_p1_push  = P1ReqValid & P1ReqReady & (P1ReqOp != 2'b00);
  assign w_p0_in    = '{op: P0ReqOp, addr: P0ReqAddr, data: P0ReqData};
  assign w_p1_in    = '{op: P1ReqOp, addr: P1ReqAddr, data: P1ReqData};

  dir_req_fifo #(.W(REQ_W), .DEPTH(DEPTH)) u_p0_fifo (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .i_push  (w_p0_push),
    .i_pop   (w_accept & ~r_proc),
    .i_dat   (w_p0_in),
    .o_dat   (w_p0_head),
    .o_full  (w_p0_full),
    .o_empty (w_p0_empty)
  );

  dir_req_fifo #(.W(REQ_W), .DEPTH(DEPTH)) u_p1_fifo (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .i_push  (w_p1_push),
    .i_pop   (w_accept & r_proc),
    .i_dat   (w_p1_in),
    .o_dat   (w_p1_head),
    .o_full  (w_p1_full),
    .o_empty (w_p1_empty)
  );

  // Writebacks outrank misses; equal classes fall back to the round-robin pointer.
  assign w_wb0 = ~w_p0_empty & (w_p0_head.op == 2'b11);
  assign w_wb1 = ~w_p1_empty & (w_p1_head.op == 2'b11);

  always_comb begin
    w_sel = 1'b0;
    if (w_p0_empty)        w_sel = 1'b1;
    else if (w_p1_empty)   w_sel = 1'b0;
    else if (w_wb0 != w_wb1) w_sel = w_wb1;
    else                   w_sel = r_rr;
  end

  assign w_win = w_sel ? w_p1_head : w_p0_head;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_p0_empty || !w_p1_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (DirReqReady) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (DirDone) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vld  <= 1'b0;
      r_req  <= '0;
      r_proc <= 1'b0;
      r_rr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_vld  <= 1'b1;
        r_req  <= w_win;
        r_proc <= w_sel;
      end
      if (w_accept) begin
        r_vld <= 1'b0;
        r_rr  <= ~r_proc;
      end
    end
  end

  assign DirReqValid = r_vld;
  assign DirReqOp    = r_req.op;
  assign DirReqAddr  = r_req.addr;
  assign DirReqData  = r_req.data;
  assign DirReqProc  = r_proc;
endmodule

// File: tb/tb_dir_request_arbiter.sv
// Directed bench for dir_request_arbiter; offered transaction packed as {valid, op, addr, data, proc}.
module tb_dir_request_arbiter;
  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       P0ReqValid, P1ReqValid;
  logic       P0ReqReady, P1ReqReady;
  logic [1:0] P0ReqOp, P1ReqOp;
  logic [3:0] P0ReqAddr, P1ReqAddr, P0ReqData, P1ReqData;
  logic       DirReqValid, DirReqReady, DirReqProc, DirDone;
  logic [1:0] DirReqOp;
  logic [3:0] DirReqAddr, DirReqData;
  logic [11:0] w_dir;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  assign w_dir = {DirReqValid, DirReqOp, DirReqAddr, DirReqData, DirReqProc};

  dir_request_arbiter #(.ADDR_W(4), .DATA_W(4), .DEPTH(2)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .P0ReqValid  (P0ReqValid),
    .P0ReqReady  (P0ReqReady),
    .P0ReqOp     (P0ReqOp),
    .P0ReqAddr   (P0ReqAddr),
    .P0ReqData   (P0ReqData),
    .P1ReqValid  (P1ReqValid),
    .P1ReqReady  (P1ReqReady),
    .P1ReqOp     (P1ReqOp),
    .P1ReqAddr   (P1ReqAddr),
    .P1ReqData   (P1ReqData),
    .DirReqValid (DirReqValid),
    .DirReqReady (DirReqReady),
    .DirReqOp    (DirReqOp),
    .DirReqAddr  (DirReqAddr),
    .DirReqData  (DirReqData),
    .DirReqProc  (DirReqProc),
    .DirDone     (DirDone)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push2(input logic v0, input logic [1:0] op0, input logic [3:0] a0, input logic [3:0] d0,
                       input logic v1, input logic [1:0] op1, input logic [3:0] a1, input logic [3:0] d1);
    P0ReqValid = v0; P0ReqOp = op0; P0ReqAddr = a0; P0ReqData = d0;
    P1ReqValid = v1; P1ReqOp = op1; P1ReqAddr = a1; P1ReqData = d1;
    tick();
    P0ReqValid = 1'b0;
    P1ReqValid = 1'b0;
  endtask

  task automatic done_pulse();
    DirDone = 1'b1;
    tick();
    DirDone = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    P0ReqValid = 1'b0; P0ReqOp = 2'b00; P0ReqAddr = 4'h0; P0ReqData = 4'h0;
    P1ReqValid = 1'b0; P1ReqOp = 2'b00; P1ReqAddr = 4'h0; P1ReqData = 4'h0;
    DirReqReady = 1'b1;
    DirDone = 1'b0;
    tick(); tick();
    checks++;
    if (w_dir !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %03h want 000", w_dir);
    end
    checks++;
    if ({P0ReqReady, P1ReqReady} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b want 11", {P0ReqReady, P1ReqReady});
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_miss();
    push2(1'b1, 2'b01, 4'h1, 4'h0, 1'b0, 2'b00, 4'h0, 4'h0);
    checks++;
    if (DirReqValid !== 1'b0) begin
      errors++; $display("FAIL rd_not_early: got valid %b want 0", DirReqValid);
    end
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b01, 4'h1, 4'h0, 1'b0}) begin
      errors++; $display("FAIL rd_offer: got %03h want %03h", w_dir, {1'b1, 2'b01, 4'h1, 4'h0, 1'b0});
    end
    tick(); tick(); tick();
    checks++;
    if (w_dir !== {1'b0, 2'b01, 4'h1, 4'h0, 1'b0}) begin
      errors++; $display("FAIL rd_wait_low: got %03h want %03h", w_dir, {1'b0, 2'b01, 4'h1, 4'h0, 1'b0});
    end
    done_pulse();
  endtask

  task automatic test_same_cycle();
    push2(1'b1, 2'b10, 4'h3, 4'h2, 1'b1, 2'b01, 4'h3, 4'h0);
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b10, 4'h3, 4'h2, 1'b0}) begin
      errors++; $display("FAIL sc_p0_first: got %03h want %03h", w_dir, {1'b1, 2'b10, 4'h3, 4'h2, 1'b0});
    end
    tick(); tick();
    checks++;
    if (w_dir !== {1'b0, 2'b10, 4'h3, 4'h2, 1'b0}) begin
      errors++; $display("FAIL sc_hold_p1: got %03h want %03h", w_dir, {1'b0, 2'b10, 4'h3, 4'h2, 1'b0});
    end
    done_pulse();
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b01, 4'h3, 4'h0, 1'b1}) begin
      errors++; $display("FAIL sc_p1_second: got %03h want %03h", w_dir, {1'b1, 2'b01, 4'h3, 4'h0, 1'b1});
    end
    tick();
    done_pulse();
    // Round-robin pointer should be back on P0 after serving P1.
    push2(1'b1, 2'b01, 4'h4, 4'h0, 1'b1, 2'b01, 4'h5, 4'h0);
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b01, 4'h4, 4'h0, 1'b0}) begin
      errors++; $display("FAIL sc_rr_p0: got %03h want %03h", w_dir, {1'b1, 2'b01, 4'h4, 4'h0, 1'b0});
    end
    tick();
    done_pulse();
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b01, 4'h5, 4'h0, 1'b1}) begin
      errors++; $display("FAIL sc_rr_p1: got %03h want %03h", w_dir, {1'b1, 2'b01, 4'h5, 4'h0, 1'b1});
    end
    tick();
    done_pulse();
  endtask

  task automatic test_wb_priority();
    push2(1'b1, 2'b01, 4'h7, 4'h0, 1'b0, 2'b00, 4'h0, 4'h0);
    tick();
    tick();
    push2(1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 2'b10, 4'h5, 4'h1);
    push2(1'b1, 2'b11, 4'h2, 4'h6, 1'b0, 2'b00, 4'h0, 4'h0);
    checks++;
    if (w_dir !== {1'b0, 2'b01, 4'h7, 4'h0, 1'b0}) begin
      errors++; $display("FAIL wb_wait_low: got %03h want %03h", w_dir, {1'b0, 2'b01, 4'h7, 4'h0, 1'b0});
    end
    done_pulse();
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b11, 4'h2, 4'h6, 1'b0}) begin
      errors++; $display("FAIL wb_first: got %03h want %03h", w_dir, {1'b1, 2'b11, 4'h2, 4'h6, 1'b0});
    end
    tick();
    done_pulse();
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b10, 4'h5, 4'h1, 1'b1}) begin
      errors++; $display("FAIL wb_miss_next: got %03h want %03h", w_dir, {1'b1, 2'b10, 4'h5, 4'h1, 1'b1});
    end
    tick();
    done_pulse();
  endtask

  task automatic test_full_stall();
    DirReqReady = 1'b0;
    P0ReqValid = 1'b1; P0ReqOp = 2'b01; P0ReqAddr = 4'h8; P0ReqData = 4'h0;
    tick();
    checks++;
    if (P0ReqReady !== 1'b1) begin
      errors++; $display("FAIL full_one_ready: got %b want 1", P0ReqReady);
    end
    P0ReqOp = 2'b10; P0ReqAddr = 4'h9; P0ReqData = 4'h3;
    tick();
    checks++;
    if (P0ReqReady !== 1'b0) begin
      errors++; $display("FAIL full_two_ready: got %b want 0", P0ReqReady);
    end
    P0ReqOp = 2'b01; P0ReqAddr = 4'hA; P0ReqData = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({P0ReqReady, w_dir} !== {1'b0, 1'b1, 2'b01, 4'h8, 4'h0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rdy %b dir %03h want rdy 0 dir %03h", i, P0ReqReady, w_dir,
                 {1'b1, 2'b01, 4'h8, 4'h0, 1'b0});
      end
    end
    P0ReqValid = 1'b0;
    DirReqReady = 1'b1;
    tick();
    checks++;
    if ({P0ReqReady, DirReqValid} !== 2'b10) begin
      errors++; $display("FAIL full_drain: got rdy/vld %b want 10", {P0ReqReady, DirReqValid});
    end
    done_pulse();
    tick();
    checks++;
    if (w_dir !== {1'b1, 2'b10, 4'h9, 4'h3, 1'b0}) begin
      errors++; $display("FAIL full_second: got %03h want %03h", w_dir, {1'b1, 2'b10, 4'h9, 4'h3, 1'b0});
    end
    tick();
    done_pulse();
    tick(); tick(); tick();
    checks++;
    if (w_dir !== {1'b0, 2'b10, 4'h9, 4'h3, 1'b0}) begin
      errors++; $display("FAIL full_extra_dropped: got %03h want %03h", w_dir, {1'b0, 2'b10, 4'h9, 4'h3, 1'b0});
    end
  endtask

  task automatic test_reset_in_wait();
    push2(1'b1, 2'b01, 4'hC, 4'h0, 1'b0, 2'b00, 4'h0, 4'h0);
    tick();
    tick();
    push2(1'b1, 2'b10, 4'hE, 4'h5, 1'b1, 2'b01, 4'hD, 4'h0);
    checks++;
    if (w_dir !== {1'b0, 2'b01, 4'hC, 4'h0, 1'b0}) begin
      errors++; $display("FAIL rw_pre: got %03h want %03h", w_dir, {1'b0, 2'b01, 4'hC, 4'h0, 1'b0});
    end
    Reset_n = 1'b0;
    #1;
    checks++;
    if (w_dir !== 12'h000) begin
      errors++; $display("FAIL rw_async_zero: got %03h want 000", w_dir);
    end
    tick(); tick();
    Reset_n = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({P0ReqReady, P1ReqReady, w_dir} !== {2'b11, 12'h000}) begin
      errors++; $display("FAIL rw_after: got rdy %b dir %03h want rdy 11 dir 000", {P0ReqReady, P1ReqReady}, w_dir);
    end
  endtask

  task automatic test_ignored();
    DirReqReady = 1'b0;
    done_pulse();
    tick();
    checks++;
    if (DirReqValid !== 1'b0) begin
      errors++; $display("FAIL ig_idle_done: got valid %b want 0", DirReqValid);
    end
    push2(1'b1, 2'b11, 4'h6, 4'h9, 1'b0, 2'b00, 4'h0, 4'h0);
    tick();
    done_pulse();
    checks++;
    if (w_dir !== {1'b1, 2'b11, 4'h6, 4'h9, 1'b0}) begin
      errors++; $display("FAIL ig_offer_done: got %03h want %03h", w_dir, {1'b1, 2'b11, 4'h6, 4'h9, 1'b0});
    end
    DirReqReady = 1'b1;
    tick();
    done_pulse();
    push2(1'b1, 2'b00, 4'h3, 4'h1, 1'b1, 2'b00, 4'h4, 4'h2);
    tick(); tick(); tick();
    checks++;
    if ({P0ReqReady, P1ReqReady, w_dir} !== {2'b11, 1'b0, 2'b11, 4'h6, 4'h9, 1'b0}) begin
      errors++;
      $display("FAIL ig_op_none: got rdy %b dir %03h want rdy 11 dir %03h", {P0ReqReady, P1ReqReady}, w_dir,
               {1'b0, 2'b11, 4'h6, 4'h9, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_reset();
    test_same_cycle();
    test_wb_priority();
    test_full_stall();
    test_reset_in_wait();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
